// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch front end: word width, halt marker,
// fetch state encoding and the {pc, inst} record carried through the buffer.
package cpu_pkg;

    localparam int INST_WIDTH = 32;
    localparam logic [INST_WIDTH-1:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]           pc;
        logic [INST_WIDTH-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetched {pc, inst} records.
// Push is ignored when full and pop when empty; flush empties the buffer
// and overrides any push or pop requested in the same cycle.
module fetch_buf
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    fetch_entry_t entries [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = entries[rd_ptr];

    // Occupancy and pointer bookkeeping; reset and flush both empty the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            entries[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: walks a word-addressed PC through the instruction
// image, queues fetched words in a 2-entry buffer, and stops on the halt
// word (HALT) or on a PC outside the image (FAULT). A redirect flushes the
// buffer and restarts fetching from the new address.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter int          INST_DEPTH = 200,
    parameter logic [31:0] RESET_PC   = 32'd0
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INST_WIDTH-1:0] mem_inst [INST_DEPTH],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic [31:0]           out_pc,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  halted,
    output logic                  fault
);

    localparam int AW = (INST_DEPTH > 1) ? $clog2(INST_DEPTH) : 1;

    fetch_state_t          state;
    logic [31:0]           pc;
    logic                  in_range;
    logic [INST_WIDTH-1:0] rd_word;
    logic                  is_halt;
    logic                  fetch_en;
    logic                  push;
    logic                  pop;
    logic                  buf_full;
    logic                  buf_empty;
    fetch_entry_t          buf_head;
    fetch_entry_t          buf_din;

    // Combinational image read, gated so an out-of-range PC never touches memory.
    always_comb begin
        in_range = (pc < 32'(INST_DEPTH));
        rd_word  = '0;
        if (in_range) begin
            rd_word = mem_inst[pc[AW-1:0]];
        end
        is_halt  = (rd_word == HALT_WORD);
        fetch_en = (state == RUN) && !buf_full && !redirect_valid;
        push     = fetch_en && in_range && !is_halt;
        buf_din  = '{pc: pc, inst: rd_word};
    end

    // PC and fetch state; a redirect wins over everything and re-enters RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            state <= RUN;
        end else if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= RUN;
        end else if (fetch_en) begin
            if (!in_range) begin
                state <= FAULT;
            end else if (is_halt) begin
                state <= HALT;
            end else begin
                pc <= pc + 32'd1;
            end
        end
    end

    fetch_buf u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (buf_din),
        .full  (buf_full),
        .empty (buf_empty),
        .head  (buf_head)
    );

    // Head is zeroed when empty so stale entries never show on the outputs.
    always_comb begin
        out_valid = !buf_empty;
        pop       = out_valid && out_ready;
        out_inst  = out_valid ? buf_head.inst : '0;
        out_pc    = out_valid ? buf_head.pc   : '0;
        halted    = (state == HALT);
        fault     = (state == FAULT);
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based model.
module tb_inst_fetch;

    localparam int DEPTH = 200;
    localparam int S_RUN = 0, S_HALT = 1, S_FAULT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        out_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] mem [DEPTH];
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        halted;
    logic        fault;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    ent_t        q [$];
    logic [31:0] m_pc;
    int          m_st;
    logic [31:0] seen [$];

    inst_fetch #(.INST_DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_inst       (mem),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == 32'hFFFF_FFFF) w = 32'h0;
        return w;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc = 32'd0;
        m_st = S_RUN;
    endtask

    // One clock edge of the intended behaviour, using the inputs held across it.
    task automatic model_step();
        bit was_full;
        bit take;
        was_full = (q.size() == 2);
        take     = (q.size() != 0) && out_ready;
        if (redirect_valid) begin
            q.delete();
            m_pc = redirect_pc;
            m_st = S_RUN;
        end else begin
            if (take) void'(q.pop_front());
            if (m_st == S_RUN && !was_full) begin
                if (m_pc >= 32'(DEPTH)) begin
                    m_st = S_FAULT;
                end else if (mem[m_pc[7:0]] == 32'hFFFF_FFFF) begin
                    m_st = S_HALT;
                end else begin
                    q.push_back('{m_pc, mem[m_pc[7:0]]});
                    m_pc = m_pc + 32'd1;
                end
            end
        end
    endtask

    task automatic compare();
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_inst", out_inst, q[0].inst);
        end
        chk("halted", {31'd0, halted}, {31'd0, m_st == S_HALT});
        chk("fault", {31'd0, fault}, {31'd0, m_st == S_FAULT});
    endtask

    // Called with inputs settled after a falling edge; records a transfer,
    // advances the model on the rising edge, compares on the falling edge.
    task automatic tick();
        if (out_valid && out_ready && !rst) seen.push_back(out_pc);
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        compare();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = rand_word();
        mem[0]   = 32'h2001_0000;
        mem[1]   = 32'hAFDF_0000;
        mem[2]   = 32'h23DE_0001;
        mem[107] = 32'h0000_0000;
        mem[123] = 32'h0800_006B;
        mem[124] = 32'hFFFF_FFFF;
        model_reset();

        // Reset state
        #3;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_inst", out_inst, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        compare();

        // Straight-line fetch with consumer always ready
        rst = 1'b0;
        out_ready = 1'b1;
        tick(); chk("seq_pc0", out_pc, 32'd0); chk("seq_inst0", out_inst, 32'h2001_0000);
        tick(); chk("seq_pc1", out_pc, 32'd1); chk("seq_inst1", out_inst, 32'hAFDF_0000);
        tick(); chk("seq_pc2", out_pc, 32'd2); chk("seq_inst2", out_inst, 32'h23DE_0001);

        // Back-pressure: head must hold, then drain in order without repeats
        rst = 1'b1; out_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick(); chk("bp_first_valid", {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick(); chk("bp_hold_inst", out_inst, 32'h2001_0000);
        end
        seen.delete();
        out_ready = 1'b1;
        repeat (6) tick();
        chk("bp_seen_count_ge4", {31'd0, seen.size() >= 4}, 32'd1);
        for (int k = 0; k < 4 && k < seen.size(); k++) chk("bp_order", seen[k], 32'(k));

        // Redirect with a full buffer discards stale entries
        out_ready = 1'b0;
        repeat (3) tick();
        redirect_valid = 1'b1; redirect_pc = 32'd107;
        tick();
        redirect_valid = 1'b0;
        tick(); chk("redir_pc", out_pc, 32'd107); chk("redir_inst", out_inst, 32'd0);
        seen.delete();
        out_ready = 1'b1;
        repeat (4) tick();
        for (int k = 0; k < seen.size(); k++) chk("redir_after", seen[k], 32'(107 + k));

        // Halt word stops fetch; redirect leaves HALT
        redirect_valid = 1'b1; redirect_pc = 32'd123;
        tick();
        redirect_valid = 1'b0;
        tick(); chk("halt_pc123", out_pc, 32'd123); chk("halt_inst123", out_inst, 32'h0800_006B);
        tick(); chk("halt_set", {31'd0, halted}, 32'd1); chk("halt_novalid", {31'd0, out_valid}, 32'd0);
        repeat (3) tick();
        chk("halt_sticky", {31'd0, halted}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'd0;
        tick();
        redirect_valid = 1'b0;
        chk("halt_clear", {31'd0, halted}, 32'd0);
        tick(); chk("halt_resume_pc", out_pc, 32'd0); chk("halt_resume_v", {31'd0, out_valid}, 32'd1);

        // Out-of-image PC faults until redirected
        redirect_valid = 1'b1; redirect_pc = 32'd200;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("fault_set", {31'd0, fault}, 32'd1);
            chk("fault_novalid", {31'd0, out_valid}, 32'd0);
        end
        redirect_valid = 1'b1; redirect_pc = 32'd1;
        tick();
        redirect_valid = 1'b0;
        tick(); chk("fault_clear", {31'd0, fault}, 32'd0);
        chk("fault_resume_inst", out_inst, 32'hAFDF_0000); chk("fault_resume_pc", out_pc, 32'd1);

        // Asynchronous reset between edges with a full buffer
        out_ready = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_inst", out_inst, 32'd0);
        chk("arst_pc", out_pc, 32'd0);
        chk("arst_halted", {31'd0, halted}, 32'd0);
        chk("arst_fault", {31'd0, fault}, 32'd0);
        tick();
        rst = 1'b0; out_ready = 1'b1;
        tick(); chk("arst_resume_pc", out_pc, 32'd0); chk("arst_resume_v", {31'd0, out_valid}, 32'd1);

        // Randomized traffic over a fresh random image with scattered halts
        for (int i = 0; i < DEPTH; i++) mem[i] = rand_word();
        for (int k = 0; k < 4; k++) mem[$urandom_range(20, DEPTH - 1)] = 32'hFFFF_FFFF;
        for (int it = 0; it < 3000; it++) begin
            int sel;
            out_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 99) < 3);
            sel = $urandom_range(0, 9);
            case (sel)
                0:       redirect_pc = 32'd123;
                1:       redirect_pc = 32'd200;
                2:       redirect_pc = 32'($urandom_range(195, 260));
                default: redirect_pc = 32'($urandom_range(0, DEPTH - 1));
            endcase
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        redirect_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
